// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order reorder buffer between dispatch and retire.
// Dispatch pushes up to WIDTH packets at the tail. Retire sees the oldest
// WIDTH entries and pops however many it reports. A mispredict restore
// squashes everything younger than the branch in one cycle.
// Optional feature: define ROB_PERF_CNT_EN to add the rob_full_cycles and
// rob_retired_total performance counters.
`ifndef N
`define N 3
`endif

module reorder_buffer #(
  parameter int ROB_SZ   = 32,
  parameter int WIDTH    = `N,
  parameter int DATA_W   = 32,
  parameter int IDX_BITS = $clog2(ROB_SZ),
  parameter int CNT_BITS = $clog2(ROB_SZ + 1),
  parameter int NS_BITS  = $clog2(WIDTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   rob_inputs [WIDTH],
  input  logic [NS_BITS-1:0]  rob_inputs_valid,
  output logic [NS_BITS-1:0]  rob_spots,
  output logic [IDX_BITS-1:0] rob_tail,
  output logic [DATA_W-1:0]   rob_outputs [WIDTH],
  output logic [NS_BITS-1:0]  rob_outputs_valid,
  input  logic [NS_BITS-1:0]  num_retiring,
  input  logic                tail_restore_valid,
  input  logic [IDX_BITS-1:0] tail_restore
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]         rob_full_cycles,
  output logic [31:0]         rob_retired_total
`endif
);

  localparam logic [CNT_BITS-1:0] ROB_SZ_C = CNT_BITS'(ROB_SZ);
  localparam logic [CNT_BITS-1:0] WIDTH_C  = CNT_BITS'(WIDTH);

  logic [DATA_W-1:0]   entries_q [ROB_SZ];
  logic [IDX_BITS-1:0] head_q, head_d;
  logic [IDX_BITS-1:0] tail_q, tail_d;
  logic [IDX_BITS-1:0] restore_span;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_BITS-1:0] free_cnt;

  // Next head/tail/count: pops always apply; a restore overrides dispatch.
  always_comb begin
    head_d       = head_q + IDX_BITS'(num_retiring);
    restore_span = tail_restore - head_d;
    if (tail_restore_valid) begin
      // The branch survives, so the live range is head_d..tail_restore inclusive.
      tail_d  = tail_restore + IDX_BITS'(1);
      count_d = CNT_BITS'(restore_span) + CNT_BITS'(1);
    end else begin
      tail_d  = tail_q + IDX_BITS'(rob_inputs_valid);
      count_d = count_q + CNT_BITS'(rob_inputs_valid) - CNT_BITS'(num_retiring);
    end
  end

  // Pointer and occupancy state; asynchronous reset empties the buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write dispatched packets at the tail; nothing is written in a restore cycle.
  // Entry contents are don't-care outside the live range. A write on an edge
  // where reset is low lands beyond the (empty) live range and is never seen.
  always_ff @(posedge clock) begin
    if (!tail_restore_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (NS_BITS'(i) < rob_inputs_valid) begin
          entries_q[tail_q + IDX_BITS'(i)] <= rob_inputs[i];
        end
      end
    end
  end

  // Outputs are derived from registered state only.
  always_comb begin
    free_cnt          = ROB_SZ_C - count_q;
    rob_spots         = (free_cnt < WIDTH_C) ? NS_BITS'(free_cnt) : NS_BITS'(WIDTH);
    rob_outputs_valid = (count_q < WIDTH_C) ? NS_BITS'(count_q) : NS_BITS'(WIDTH);
    rob_tail          = tail_q;
    for (int i = 0; i < WIDTH; i++) begin
      rob_outputs[i] = entries_q[head_q + IDX_BITS'(i)];
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] full_cycles_q;
  logic [31:0] retired_total_q;

  // Free-running performance counters; both wrap on overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_cycles_q   <= '0;
      retired_total_q <= '0;
    end else begin
      if (count_q == ROB_SZ_C) begin
        full_cycles_q <= full_cycles_q + 32'd1;
      end
      retired_total_q <= retired_total_q + 32'(num_retiring);
    end
  end

  assign rob_full_cycles   = full_cycles_q;
  assign rob_retired_total = retired_total_q;
`endif

`ifndef SYNTHESIS
  logic [IDX_BITS-1:0] restore_off;
  assign restore_off = tail_restore - head_q;

  a_dispatch_overflow: assert property (@(posedge clock) disable iff (!reset)
    rob_inputs_valid <= rob_spots);
  a_retire_overflow: assert property (@(posedge clock) disable iff (!reset)
    num_retiring <= rob_outputs_valid);
  // The branch must be live now and must not be popped in the restore cycle.
  a_restore_live: assert property (@(posedge clock) disable iff (!reset)
    tail_restore_valid |-> ((CNT_BITS'(restore_off) < count_q) &&
                            (restore_off >= IDX_BITS'(num_retiring))));
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and randomized checks of reorder_buffer against
// a queue-based model of the buffer contents.
module tb_reorder_buffer;

  localparam int ROB_SZ = 32;
  localparam int W      = 3;
  localparam int IDX    = 5;
  localparam int NS     = 2;
  localparam int DW     = 32;
  localparam logic [DW-1:0] PKT_BASE = 32'hC0DE_0000;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [DW-1:0]  rob_inputs [W];
  logic [NS-1:0]  rob_inputs_valid;
  logic [NS-1:0]  rob_spots;
  logic [IDX-1:0] rob_tail;
  logic [DW-1:0]  rob_outputs [W];
  logic [NS-1:0]  rob_outputs_valid;
  logic [NS-1:0]  num_retiring;
  logic           tail_restore_valid;
  logic [IDX-1:0] tail_restore;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]    rob_full_cycles;
  logic [31:0]    rob_retired_total;
`endif

  always #5 clock = ~clock;

  reorder_buffer #(.ROB_SZ(ROB_SZ), .WIDTH(W), .DATA_W(DW)) dut (
    .clock              (clock),
    .reset              (reset),
    .rob_inputs         (rob_inputs),
    .rob_inputs_valid   (rob_inputs_valid),
    .rob_spots          (rob_spots),
    .rob_tail           (rob_tail),
    .rob_outputs        (rob_outputs),
    .rob_outputs_valid  (rob_outputs_valid),
    .num_retiring       (num_retiring),
    .tail_restore_valid (tail_restore_valid),
    .tail_restore       (tail_restore)
`ifdef ROB_PERF_CNT_EN
    ,
    .rob_full_cycles    (rob_full_cycles),
    .rob_retired_total  (rob_retired_total)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the live entries oldest-first, plus pointer positions.
  logic [DW-1:0] mq[$];
  int m_head = 0;
  int m_tail = 0;
  int m_full = 0;
  int m_ret  = 0;
  int pkt_no = 0;

  function automatic int exp_spots();
    int f = ROB_SZ - mq.size();
    return (f < W) ? f : W;
  endfunction

  function automatic int exp_valid();
    return (mq.size() < W) ? mq.size() : W;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < W; i++) rob_inputs[i] = '0;
    rob_inputs_valid   = '0;
    num_retiring       = '0;
    tail_restore_valid = 1'b0;
    tail_restore       = '0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_head = 0; m_tail = 0; m_full = 0; m_ret = 0; pkt_no = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
    model_clear();
  endtask

  // One clock of stimulus; the model advances by the buffer's rules.
  task automatic drive_cycle(input int nin, input int nret, input bit rv,
                             input int rt, input bit rnd);
    int keep;
    for (int i = 0; i < W; i++) begin
      if (i < nin) begin
        pkt_no++;
        rob_inputs[i] = rnd ? $urandom : PKT_BASE + DW'(pkt_no);
      end else begin
        rob_inputs[i] = '0;
      end
    end
    rob_inputs_valid   = NS'(nin);
    num_retiring       = NS'(nret);
    tail_restore_valid = rv;
    tail_restore       = IDX'(rt);
    @(posedge clock);
    if (mq.size() == ROB_SZ) m_full++;
    m_ret += nret;
    for (int i = 0; i < nret; i++) void'(mq.pop_front());
    m_head = (m_head + nret) % ROB_SZ;
    if (rv) begin
      keep = ((rt - m_head) % ROB_SZ + ROB_SZ) % ROB_SZ + 1;
      while (mq.size() > keep) void'(mq.pop_back());
      m_tail = (rt + 1) % ROB_SZ;
    end else begin
      for (int i = 0; i < nin; i++) mq.push_back(rob_inputs[i]);
      m_tail = (m_tail + nin) % ROB_SZ;
    end
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (rob_spots !== NS'(3)) begin errors++; $display("FAIL rst_spots got=%0d exp=3", rob_spots); end
    checks++; if (rob_outputs_valid !== NS'(0)) begin errors++; $display("FAIL rst_valid got=%0d exp=0", rob_outputs_valid); end
    checks++; if (rob_tail !== IDX'(0)) begin errors++; $display("FAIL rst_tail got=%0d exp=0", rob_tail); end
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    @(negedge clock);
    checks++; if (rob_spots !== NS'(3)) begin errors++; $display("FAIL rst_rel_spots got=%0d exp=3", rob_spots); end
    // Build up count=10, then reset asynchronously with activity on the inputs.
    drive_cycle(3, 0, 0, 0, 0);
    drive_cycle(3, 0, 0, 0, 0);
    drive_cycle(3, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    checks++; if (rob_tail !== IDX'(10)) begin errors++; $display("FAIL mid_tail got=%0d exp=10", rob_tail); end
    @(negedge clock);
    rob_inputs_valid = NS'(3);
    num_retiring     = NS'(2);
    reset = 1'b0;
    #1;
    checks++; if (rob_outputs_valid !== NS'(0)) begin errors++; $display("FAIL mid_rst_valid got=%0d exp=0", rob_outputs_valid); end
    checks++; if (rob_tail !== IDX'(0)) begin errors++; $display("FAIL mid_rst_tail got=%0d exp=0", rob_tail); end
    @(posedge clock);
    #1;
    checks++; if (rob_tail !== IDX'(0)) begin errors++; $display("FAIL mid_rst_edge_tail got=%0d exp=0", rob_tail); end
    checks++; if (rob_spots !== NS'(3)) begin errors++; $display("FAIL mid_rst_edge_spots got=%0d exp=3", rob_spots); end
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    model_clear();
    #1;
    checks++; if (rob_outputs_valid !== NS'(0)) begin errors++; $display("FAIL mid_rel_valid got=%0d exp=0", rob_outputs_valid); end
  endtask

  task automatic test_fill_wrap();
    for (int c = 0; c < 11; c++) drive_cycle(exp_spots(), 0, 0, 0, 0);
    checks++; if (rob_spots !== NS'(0)) begin errors++; $display("FAIL full_spots got=%0d exp=0", rob_spots); end
    checks++; if (rob_tail !== IDX'(0)) begin errors++; $display("FAIL full_tail got=%0d exp=0", rob_tail); end
    checks++; if (rob_outputs_valid !== NS'(3)) begin errors++; $display("FAIL full_valid got=%0d exp=3", rob_outputs_valid); end
    checks++; if (rob_outputs[0] !== PKT_BASE + 32'd1) begin errors++; $display("FAIL full_slot0 got=%h exp=%h", rob_outputs[0], PKT_BASE + 32'd1); end
    drive_cycle(0, 3, 0, 0, 0);
    checks++; if (rob_spots !== NS'(3)) begin errors++; $display("FAIL pop3_spots got=%0d exp=3", rob_spots); end
    checks++; if (rob_outputs[0] !== PKT_BASE + 32'd4) begin errors++; $display("FAIL pop3_slot0 got=%h exp=%h", rob_outputs[0], PKT_BASE + 32'd4); end
    checks++; if (rob_outputs_valid !== NS'(3)) begin errors++; $display("FAIL pop3_valid got=%0d exp=3", rob_outputs_valid); end
  endtask

  task automatic test_retire_wrap();
    logic [DW-1:0] want [3];
    repeat (9) drive_cycle(0, 3, 0, 0, 0);
    drive_cycle(2, 0, 0, 0, 0);
    // head=30: entries 30,31 hold packets 31,32; entry 0 holds packet 33.
    want[0] = PKT_BASE + 32'd31; want[1] = PKT_BASE + 32'd32; want[2] = PKT_BASE + 32'd33;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rob_outputs[i] !== want[i]) begin errors++; $display("FAIL wrap_slot%0d got=%h exp=%h", i, rob_outputs[i], want[i]); end
    end
    drive_cycle(0, 3, 0, 0, 0);
    checks++; if (rob_outputs_valid !== NS'(1)) begin errors++; $display("FAIL wrap_pop_valid got=%0d exp=1", rob_outputs_valid); end
    checks++; if (rob_outputs[0] !== PKT_BASE + 32'd34) begin errors++; $display("FAIL wrap_pop_slot0 got=%h exp=%h", rob_outputs[0], PKT_BASE + 32'd34); end
    checks++; if (rob_tail !== IDX'(2)) begin errors++; $display("FAIL wrap_pop_tail got=%0d exp=2", rob_tail); end
  endtask

  task automatic test_push_pop();
    drive_cycle(3, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(2, 2, 0, 0, 0);
    checks++; if (rob_tail !== IDX'(8)) begin errors++; $display("FAIL pp_tail got=%0d exp=8", rob_tail); end
    checks++; if (rob_outputs_valid !== NS'(3)) begin errors++; $display("FAIL pp_valid got=%0d exp=3", rob_outputs_valid); end
    checks++; if (mq.size() != 5 || rob_outputs[0] !== PKT_BASE + 32'd36) begin errors++; $display("FAIL pp_slot0 got=%h exp=%h", rob_outputs[0], PKT_BASE + 32'd36); end
    // Drain and confirm FIFO order.
    for (int c = 0; c < ROB_SZ && mq.size() > 0; c++) begin
      for (int i = 0; i < exp_valid(); i++) begin
        checks++; if (rob_outputs[i] !== mq[i]) begin errors++; $display("FAIL pp_drain_slot%0d got=%h exp=%h", i, rob_outputs[i], mq[i]); end
      end
      drive_cycle(0, exp_valid(), 0, 0, 0);
    end
    checks++; if (rob_outputs_valid !== NS'(0)) begin errors++; $display("FAIL pp_empty_valid got=%0d exp=0", rob_outputs_valid); end
  endtask

  task automatic test_restore();
    logic [DW-1:0] saved [3];
    do_reset();
    drive_cycle(3, 0, 0, 0, 0);
    drive_cycle(3, 0, 0, 0, 0);
    drive_cycle(3, 0, 0, 0, 0);
    drive_cycle(3, 0, 0, 0, 0);
    drive_cycle(2, 0, 0, 0, 0);
    drive_cycle(0, 3, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0);
    // head=4, tail=14; entries 5,6,7 hold packets 6,7,8.
    saved[0] = PKT_BASE + 32'd6; saved[1] = PKT_BASE + 32'd7; saved[2] = PKT_BASE + 32'd8;
    drive_cycle(3, 1, 1, 7, 0);
    checks++; if (rob_tail !== IDX'(8)) begin errors++; $display("FAIL rs_tail got=%0d exp=8", rob_tail); end
    checks++; if (rob_outputs_valid !== NS'(3)) begin errors++; $display("FAIL rs_valid got=%0d exp=3", rob_outputs_valid); end
    checks++; if (rob_spots !== NS'(3)) begin errors++; $display("FAIL rs_spots got=%0d exp=3", rob_spots); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rob_outputs[i] !== saved[i]) begin errors++; $display("FAIL rs_slot%0d got=%h exp=%h", i, rob_outputs[i], saved[i]); end
    end
    // Restore to the newest entry leaves the live range intact.
    drive_cycle(0, 0, 1, 7, 0);
    checks++; if (rob_tail !== IDX'(8)) begin errors++; $display("FAIL rs_newest_tail got=%0d exp=8", rob_tail); end
    checks++; if (rob_outputs_valid !== NS'(3)) begin errors++; $display("FAIL rs_newest_valid got=%0d exp=3", rob_outputs_valid); end
    drive_cycle(0, 3, 0, 0, 0);
    checks++; if (rob_outputs_valid !== NS'(0)) begin errors++; $display("FAIL rs_drain_valid got=%0d exp=0", rob_outputs_valid); end
    drive_cycle(1, 0, 0, 0, 0);
    checks++; if (rob_tail !== IDX'(9)) begin errors++; $display("FAIL rs_after_tail got=%0d exp=9", rob_tail); end
  endtask

  task automatic test_random();
    int nin, nret, rt, off;
    bit rv;
    for (int c = 0; c < 400; c++) begin
      nin  = $urandom_range(0, exp_spots());
      nret = $urandom_range(0, exp_valid());
      rv   = 1'b0;
      rt   = 0;
      if (($urandom_range(0, 9) == 0) && (mq.size() > nret)) begin
        rv  = 1'b1;
        off = $urandom_range(nret, mq.size() - 1);
        rt  = (m_head + off) % ROB_SZ;
      end
      drive_cycle(nin, nret, rv, rt, 1'b1);
      checks++; if (rob_spots !== NS'(exp_spots())) begin errors++; $display("FAIL rnd_spots cyc=%0d got=%0d exp=%0d", c, rob_spots, exp_spots()); end
      checks++; if (rob_outputs_valid !== NS'(exp_valid())) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0d exp=%0d", c, rob_outputs_valid, exp_valid()); end
      checks++; if (rob_tail !== IDX'(m_tail)) begin errors++; $display("FAIL rnd_tail cyc=%0d got=%0d exp=%0d", c, rob_tail, m_tail); end
      for (int i = 0; i < exp_valid(); i++) begin
        checks++; if (rob_outputs[i] !== mq[i]) begin errors++; $display("FAIL rnd_slot%0d cyc=%0d got=%h exp=%h", i, c, rob_outputs[i], mq[i]); end
      end
    end
  endtask

`ifdef ROB_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    checks++; if (rob_full_cycles !== 32'd0) begin errors++; $display("FAIL perf_rst_full got=%0d exp=0", rob_full_cycles); end
    for (int c = 0; c < 11; c++) drive_cycle(exp_spots(), 0, 0, 0, 0);
    repeat (4) drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(0, 3, 0, 0, 0);
    drive_cycle(0, 2, 0, 0, 0);
    checks++; if (rob_full_cycles !== 32'd5) begin errors++; $display("FAIL perf_full got=%0d exp=5", rob_full_cycles); end
    checks++; if (rob_retired_total !== 32'd5) begin errors++; $display("FAIL perf_retired got=%0d exp=5", rob_retired_total); end
    checks++; if (rob_full_cycles !== 32'(m_full)) begin errors++; $display("FAIL perf_full_model got=%0d exp=%0d", rob_full_cycles, m_full); end
    checks++; if (rob_retired_total !== 32'(m_ret)) begin errors++; $display("FAIL perf_ret_model got=%0d exp=%0d", rob_retired_total, m_ret); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_wrap();
    test_retire_wrap();
    test_push_pop();
    test_restore();
    test_random();
`ifdef ROB_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
